// File: rtl/lab4_net_bus_net_eject_unit.sv
`default_nettype none
// ============================================================================
// lab4_net_bus_net_eject_unit : bus-side receive terminal with FIFO, checks, counters
// Revision: 1.0
// ============================================================================
module lab4_net_bus_net_eject_unit #(
   parameter int p_port_id       = 0,
   parameter int p_opaque_nbits  = 8,
   parameter int p_payload_nbits = 32,
   parameter int p_depth         = 4
)(
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          in_val,
   output logic                                          in_rdy,
   input  logic [4+p_opaque_nbits+p_payload_nbits-1:0]   in_msg,
   output logic                                          out_val,
   input  logic                                          out_rdy,
   output logic [4+p_opaque_nbits+p_payload_nbits-1:0]   out_msg,
   input  logic                                          err_clr,
   output logic                                          misroute_err,
   output logic                                          order_err,
   output logic [31:0]                                   recv_count
);

   localparam int c_msg_nbits = 4 + p_opaque_nbits + p_payload_nbits;
   localparam int c_ptr_nbits = $clog2(p_depth);
   localparam int c_cnt_nbits = $clog2(p_depth + 1);
   localparam int c_opq_lsb   = p_payload_nbits;
   localparam int c_src_lsb   = p_payload_nbits + p_opaque_nbits;
   localparam int c_dest_lsb  = c_src_lsb + 2;
   localparam logic [c_cnt_nbits-1:0] c_full_cnt = c_cnt_nbits'(p_depth);
   localparam logic [1:0]             c_port     = 2'(p_port_id);

   logic [c_msg_nbits-1:0]    mem_q [p_depth];
   logic [c_ptr_nbits-1:0]    head_q, head_d;
   logic [c_ptr_nbits-1:0]    tail_q, tail_d;
   logic [c_cnt_nbits-1:0]    count_q, count_d;
   logic [p_opaque_nbits-1:0] exp_q [4];
   logic [p_opaque_nbits-1:0] exp_d [4];
   logic [7:0]                rcnt_q [4];
   logic [7:0]                rcnt_d [4];
   logic                      mis_q, mis_d;
   logic                      ord_q, ord_d;

   logic                      w_full;
   logic                      w_acc;
   logic                      w_enq;
   logic                      w_deq;
   logic                      w_mis_evt;
   logic                      w_ord_evt;
   logic [1:0]                w_in_dest;
   logic [1:0]                w_in_src;
   logic [p_opaque_nbits-1:0] w_in_opq;
   logic [1:0]                w_head_src;

   assign w_in_dest  = in_msg[c_dest_lsb +: 2];
   assign w_in_src   = in_msg[c_src_lsb +: 2];
   assign w_in_opq   = in_msg[c_opq_lsb +: p_opaque_nbits];
   assign w_head_src = out_msg[c_src_lsb +: 2];

   // in_rdy depends only on reset and the registered count, never on out_rdy
   assign w_full  = (count_q == c_full_cnt);
   assign in_rdy  = !reset && !w_full;
   assign out_val = (count_q != '0);
   assign out_msg = mem_q[head_q];

   assign w_acc     = in_val && in_rdy;
   assign w_enq     = w_acc && (w_in_dest == c_port);
   assign w_mis_evt = w_acc && (w_in_dest != c_port);
   assign w_ord_evt = w_acc && (w_in_opq != exp_q[w_in_src]);
   assign w_deq     = out_val && out_rdy;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (w_enq) tail_d = tail_q + 1'b1;
      if (w_deq) head_d = head_q + 1'b1;
      case ({w_enq, w_deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Expected opaque always reloads so a single gap is flagged exactly once
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         exp_d[i]  = exp_q[i];
         rcnt_d[i] = rcnt_q[i];
      end
      if (w_acc) exp_d[w_in_src] = w_in_opq + 1'b1;
      if (w_deq) rcnt_d[w_head_src] = rcnt_q[w_head_src] + 8'd1;
   end

   always_comb begin
      mis_d = w_mis_evt || (mis_q && !err_clr);
      ord_d = w_ord_evt || (ord_q && !err_clr);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         mis_q   <= 1'b0;
         ord_q   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            exp_q[i]  <= '0;
            rcnt_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         mis_q   <= mis_d;
         ord_q   <= ord_d;
         for (int i = 0; i < 4; i++) begin
            exp_q[i]  <= exp_d[i];
            rcnt_q[i] <= rcnt_d[i];
         end
      end
   end

   // Storage needs no reset; w_enq is already low while reset is asserted
   always_ff @(posedge clk) begin
      if (w_enq) mem_q[tail_q] <= in_msg;
   end

   assign misroute_err = mis_q;
   assign order_err    = ord_q;

   for (genvar s = 0; s < 4; s++) begin : g_recv
      assign recv_count[8*s +: 8] = rcnt_q[s];
   end

endmodule
`default_nettype wire

// File: tb/tb_lab4_net_bus_net_eject_unit.sv
`default_nettype none
// ============================================================================
// tb_lab4_net_bus_net_eject_unit : vectors, corner sequences and random vs queue model
// Revision: 1.0
// ============================================================================
module tb_lab4_net_bus_net_eject_unit;

   localparam int c_w = 44;

   logic           clk;
   logic           reset;
   logic           in_val;
   logic           in_rdy;
   logic [c_w-1:0] in_msg;
   logic           out_val;
   logic           out_rdy;
   logic [c_w-1:0] out_msg;
   logic           err_clr;
   logic           misroute_err;
   logic           order_err;
   logic [31:0]    recv_count;

   lab4_net_bus_net_eject_unit #(
      .p_port_id(0), .p_opaque_nbits(8), .p_payload_nbits(32), .p_depth(4)
   ) dut (
      .clk(clk), .reset(reset),
      .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
      .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
      .err_clr(err_clr), .misroute_err(misroute_err), .order_err(order_err),
      .recv_count(recv_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: message queue, expected opaques, counters, flags
   logic [c_w-1:0] mq[$];
   logic [7:0]     exp_m [4];
   logic [7:0]     cnt_m [4];
   logic           mis_m, ord_m;

   typedef struct {
      logic [1:0]  d;
      logic [1:0]  s;
      logic [7:0]  o;
      logic [31:0] p;
      logic        e_mis;
      logic        e_ord;
   } vec_t;

   vec_t tv [9];

   function automatic logic [c_w-1:0] mk(input logic [1:0] d, input logic [1:0] s,
                                         input logic [7:0] o, input logic [31:0] p);
      return {d, s, o, p};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      for (int i = 0; i < 4; i++) begin
         exp_m[i] = 8'd0;
         cnt_m[i] = 8'd0;
      end
      mis_m = 1'b0;
      ord_m = 1'b0;
   endtask

   // One clock: drive, check DUT against the model, advance the model, wait for the edge
   task automatic cycle(input logic v, input logic [c_w-1:0] m, input logic ordy,
                        input logic clr, input logic rst, output logic acc);
      logic sm, so;
      logic [1:0] hs;
      @(negedge clk);
      in_val = v; in_msg = m; out_rdy = ordy; err_clr = clr; reset = rst;
      #1;
      chk("in_rdy", {63'd0, in_rdy}, {63'd0, (!rst && mq.size() < 4)});
      chk("out_val", {63'd0, out_val}, {63'd0, (mq.size() != 0)});
      if (mq.size() != 0) chk("out_msg", {20'd0, out_msg}, {20'd0, mq[0]});
      chk("misroute_err", {63'd0, misroute_err}, {63'd0, mis_m});
      chk("order_err", {63'd0, order_err}, {63'd0, ord_m});
      chk("recv_count", {32'd0, recv_count}, {32'd0, cnt_m[3], cnt_m[2], cnt_m[1], cnt_m[0]});
      acc = v && !rst && (mq.size() < 4);
      if (rst) begin
         model_reset();
      end else begin
         sm = 1'b0;
         so = 1'b0;
         if (mq.size() != 0 && ordy) begin
            hs = mq[0][41:40];
            cnt_m[hs] = cnt_m[hs] + 8'd1;
            void'(mq.pop_front());
         end
         if (acc) begin
            if (m[39:32] != exp_m[m[41:40]]) so = 1'b1;
            exp_m[m[41:40]] = m[39:32] + 8'd1;
            if (m[43:42] == 2'd0) mq.push_back(m);
            else sm = 1'b1;
         end
         mis_m = sm || (mis_m && !clr);
         ord_m = so || (ord_m && !clr);
      end
      @(posedge clk);
   endtask

   task automatic idle(input logic clr);
      logic a;
      cycle(1'b0, '0, 1'b1, clr, 1'b0, a);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic a;
      logic [c_w-1:0] m;
      logic [c_w-1:0] bp [5];
      int sent;
      int tries;
      logic [1:0] s;

      reset = 1'b1; in_val = 1'b0; in_msg = '0; out_rdy = 1'b0; err_clr = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);

      tv[0] = '{2'd0, 2'd2, 8'd0,   32'hDEADBEEF, 1'b0, 1'b0};
      tv[1] = '{2'd2, 2'd0, 8'd0,   32'h11111111, 1'b1, 1'b0};
      tv[2] = '{2'd0, 2'd1, 8'd0,   32'h22222222, 1'b0, 1'b0};
      tv[3] = '{2'd0, 2'd1, 8'd1,   32'h33333333, 1'b0, 1'b0};
      tv[4] = '{2'd0, 2'd1, 8'd3,   32'h44444444, 1'b0, 1'b1};
      tv[5] = '{2'd0, 2'd1, 8'd4,   32'h55555555, 1'b0, 1'b0};
      tv[6] = '{2'd0, 2'd3, 8'd255, 32'h66666666, 1'b0, 1'b1};
      tv[7] = '{2'd0, 2'd3, 8'd0,   32'h77777777, 1'b0, 1'b0};
      tv[8] = '{2'd0, 2'd0, 8'd1,   32'h88888888, 1'b0, 1'b0};

      idle(1'b0);
      for (int i = 0; i < 9; i++) begin
         m = mk(tv[i].d, tv[i].s, tv[i].o, tv[i].p);
         cycle(1'b1, m, 1'b1, 1'b0, 1'b0, a);
         #1;
         chk("tv_out_val", {63'd0, out_val}, {63'd0, !tv[i].e_mis});
         if (!tv[i].e_mis) chk("tv_out_msg", {20'd0, out_msg}, {20'd0, m});
         chk("tv_misroute", {63'd0, misroute_err}, {63'd0, tv[i].e_mis});
         chk("tv_order", {63'd0, order_err}, {63'd0, tv[i].e_ord});
         idle(1'b1);
         #1;
         chk("tv_cleared", {62'd0, misroute_err, order_err}, 64'd0);
      end
      chk("tv_recv_src2", {56'd0, recv_count[23:16]}, 64'd1);

      // Backpressure: 5 messages from src 1 into a 4-entry FIFO
      for (int i = 0; i < 5; i++) bp[i] = mk(2'd0, 2'd1, 8'(5 + i), 32'hB0000000 + i);
      sent = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, bp[sent], 1'b0, 1'b0, 1'b0, a);
         if (a) sent++;
      end
      #1;
      chk("bp_full_rdy", {63'd0, in_rdy}, 64'd0);
      tries = 0;
      while (sent < 5 && tries < 10) begin
         cycle(1'b1, bp[sent], 1'b1, 1'b0, 1'b0, a);
         if (a) sent++;
         tries++;
      end
      chk("bp_fifth_after_one", tries, 2);
      repeat (6) idle(1'b0);
      #1;
      chk("bp_recv_src1", {56'd0, recv_count[15:8]}, 64'd9);
      chk("bp_order", {63'd0, order_err}, 64'd0);

      // Sustained streaming, alternating src 0 and 3
      for (int i = 0; i < 20; i++) begin
         s = (i % 2 == 0) ? 2'd0 : 2'd3;
         m = mk(2'd0, s, exp_m[s], 32'h5A000000 + i);
         cycle(1'b1, m, 1'b1, 1'b0, 1'b0, a);
         #1;
         chk("stream_val", {63'd0, out_val}, 64'd1);
         chk("stream_msg", {20'd0, out_msg}, {20'd0, m});
         chk("stream_rdy", {63'd0, in_rdy}, 64'd1);
      end
      idle(1'b0);
      #1;
      chk("stream_order", {63'd0, order_err}, 64'd0);

      // Misroute with err_clr in the same cycle: the set wins
      cycle(1'b1, mk(2'd1, 2'd0, exp_m[0], 32'hCAFE0001), 1'b1, 1'b1, 1'b0, a);
      #1;
      chk("mis_set_wins", {63'd0, misroute_err}, 64'd1);
      chk("mis_not_delivered", {63'd0, out_val}, 64'd0);
      idle(1'b1);
      #1;
      chk("mis_cleared", {63'd0, misroute_err}, 64'd0);

      // Reset with three entries buffered
      for (int i = 0; i < 3; i++)
         cycle(1'b1, mk(2'd0, 2'd2, exp_m[2], 32'hAB000000 + i), 1'b0, 1'b0, 1'b0, a);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
      #1;
      chk("rst_out_val", {63'd0, out_val}, 64'd0);
      chk("rst_recv", {32'd0, recv_count}, 64'd0);
      cycle(1'b1, mk(2'd0, 2'd2, 8'd0, 32'h0BADF00D), 1'b1, 1'b0, 1'b0, a);
      #1;
      chk("rst_fresh_val", {63'd0, out_val}, 64'd1);
      chk("rst_fresh_order", {63'd0, order_err}, 64'd0);
      idle(1'b0);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         s = 2'($urandom_range(0, 3));
         m = mk(($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                s,
                ($urandom_range(0, 9) == 0) ? 8'($urandom) : exp_m[s],
                $urandom);
         cycle(1'($urandom_range(0, 1)), m, ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0), a);
      end
      repeat (6) idle(1'b0);
      idle(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lab4_net_bus_net_eject_unit.md
Name: lab4_net_bus_net_eject_unit

Overview:
- Receive-side terminal unit attached to one output port of the 4-port bus network.
- Accepts network messages from the bus via val/rdy, checks routing and per-source ordering, buffers them in a small FIFO, and drains them to the terminal sink via val/rdy.
- Keeps per-source delivery counters and sticky error flags for test and debug.

Parameters:
- p_port_id, 0: this terminal's port number (0..3); expected dest field of every arriving message.
- p_opaque_nbits, 8: opaque/sequence field width.
- p_payload_nbits, 32: payload field width.
- p_depth, 4: FIFO entries; power of two, >= 2.
- Derived c_msg_nbits = 2 + 2 + p_opaque_nbits + p_payload_nbits.
- Message layout, MSB to LSB: dest[2], src[2], opaque, payload.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_val  in  1  bus out_val bit for this port.
- in_rdy  out  1  ready back to bus.
- in_msg  in  c_msg_nbits  message from bus.
- out_val  out  1  message available to terminal.
- out_rdy  in  1  terminal ready.
- out_msg  out  c_msg_nbits  head-of-FIFO message, unmodified.
- err_clr  in  1  clears both sticky error flags.
- misroute_err  out  1  sticky; set when an accepted message has dest != p_port_id.
- order_err  out  1  sticky; set when an accepted message's opaque is not the expected value for its src.
- recv_count  out  32  four 8-bit counters of messages delivered to the terminal; [8*s+7:8*s] holds the count for src s.

Behaviour:
- Reset, synchronous: FIFO empty, out_val=0, in_rdy=0 during the reset cycle, both error flags 0, all recv_count fields 0, all expected-opaque registers 0.
- in_rdy = !full. No combinational path from out_rdy to in_rdy.
- Accept occurs when in_val && in_rdy.
- out_val = !empty.
- Dequeue occurs when out_val && out_rdy.
- Minimum latency: a message accepted in cycle N appears at out_msg with out_val=1 in cycle N+1. There is no bypass.
- out_msg is driven from the head entry and is stable while out_val && !out_rdy.
- FIFO uses wrapping head/tail pointers of log2(p_depth) bits plus a count register (0..p_depth).
- Simultaneous accept and dequeue: count unchanged, both pointers advance.
- When full: in_rdy=0; a dequeue in that cycle frees the entry for the next cycle only.
- When empty: out_val=0; out_rdy is ignored.
- Misroute handling: an accepted message with dest != p_port_id is consumed (acknowledged) but not enqueued, and misroute_err is set. Its order check and expected-opaque update are still performed.
- Order check on every accept:
  - Compare opaque with exp[src].
  - On mismatch, set order_err.
  - Always load exp[src] = opaque + 1, mod 2^p_opaque_nbits, so that one gap flags only once.
- exp registers wrap: after opaque = all-ones, exp = 0 and a following opaque of 0 is legal.
- recv_count[src of head] increments by 1, mod 256, on each dequeue.
- err_clr clears both flags next cycle. If err_clr and a new error event occur in the same cycle, the set wins.
- Reset mid-operation discards all buffered messages. out_val falls at the cycle after reset is sampled. in_rdy is 0 while reset is asserted.
- in_msg is ignored when in_val=0.
- No X may propagate to out_val or in_rdy.

Test Plan:
- Reset, then a single message with p_port_id=0 (dest=0, src=2, opaque=0, payload=0xDEADBEEF) and out_rdy=1 -> out_val=1 exactly one cycle after accept, out_msg identical, recv_count[23:16]=1, both errors 0.
- out_rdy=0, p_depth=4, send 5 back-to-back messages from src 1 with opaque 0..4 -> 4 accepted, in_rdy=0 on the 5th. Raise out_rdy -> all 5 delivered in order, 5th accepted the cycle after the first dequeue, recv_count[15:8]=5, order_err=0.
- Sustained streaming with in_val=1 and out_rdy=1 every cycle for 20 messages alternating src 0/3 -> throughput one per cycle, count never exceeds 1, order_err=0.
- Misroute: dest=2 arrives at p_port_id=0 -> in_rdy=1, message not delivered, misroute_err=1. err_clr pulse -> 0 next cycle.
- Order: src 1 sends opaque 0, 1, 3, 4 -> order_err set on opaque 3 only. Opaque 255 followed by 0 -> no error.
- Reset asserted with 3 entries buffered -> out_val=0 and recv_count=0 after reset. A fresh message with opaque 0 is accepted with no order_err.
